// File: rtl/mips_core_pkg.sv
// mips_core_pkg
// Shared definitions for the multicycle MIPS-subset core: opcode and funct
// encodings, the control FSM state type, the ALU operation type and the
// small helpers that map R-type funct fields onto ALU operations.
package mips_core_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPE_EX, ALU_WB, IMM_EX, BRANCH, JUMP, HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_t;

  // 32-bit wrap-around ALU; slt compares as two's complement.
  function automatic logic [31:0] alu_compute(alu_op_t op, logic [31:0] x, logic [31:0] y);
    case (op)
      ALU_ADD: return x + y;
      ALU_SUB: return x - y;
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_SLT: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return x + y;
    endcase
  endfunction

  function automatic alu_op_t funct_to_alu(logic [5:0] funct);
    case (funct)
      FUNCT_SUB: return ALU_SUB;
      FUNCT_AND: return ALU_AND;
      FUNCT_OR:  return ALU_OR;
      FUNCT_SLT: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  function automatic logic funct_legal(logic [5:0] funct);
    return (funct == FUNCT_ADD) || (funct == FUNCT_SUB) || (funct == FUNCT_AND) ||
           (funct == FUNCT_OR)  || (funct == FUNCT_SLT);
  endfunction

endpackage

// File: rtl/multicycle_mips_core_regfile.sv
// regfile_2r1w
// Two asynchronous read ports, one synchronous write port.
// Register 0 and any index at or above REG_COUNT read as zero and ignore
// writes, so a narrow configuration behaves like a 32-entry file with
// missing registers hard-wired to zero.
// Ports: clk, reset (async active-low), ra1/ra2 read indices, rd1/rd2 read
// data, we/wa/wd write enable, index and data.
module regfile_2r1w #(
  parameter int REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  localparam int IW = $clog2(REG_COUNT);

  logic [31:0] regs [REG_COUNT];

  function automatic logic implemented(logic [4:0] idx);
    return (idx != 5'd0) && (int'(idx) < REG_COUNT);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (we && implemented(wa)) begin
      regs[wa[IW-1:0]] <= wd;
    end
  end

  assign rd1 = implemented(ra1) ? regs[ra1[IW-1:0]] : 32'd0;
  assign rd2 = implemented(ra2) ? regs[ra2[IW-1:0]] : 32'd0;

endmodule

// File: rtl/multicycle_mips_core.sv
// multicycle_mips_core
// Multicycle MIPS-subset processor with its own control FSM. Every memory
// access is a req/ready handshake; the request, address, write flag and
// write data are registered and held until the ready cycle.
// Ports: clk, reset (async active-low); mem_req_o/mem_we_o/mem_addr_o/
// mem_wdata_o request side, mem_rdata_i/mem_ready_i response side;
// pc_o current PC, halt_o stopped on an illegal opcode, gpio_o low byte of $2.
module multicycle_mips_core
  import mips_core_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          REG_COUNT  = 32,
  parameter logic [31:0] RESET_ADDR = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  halt_o,
  output logic [7:0]            gpio_o
);

  localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_ADDR & ~32'h3);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);

  state_t                state, decode_state;
  logic [ADDR_WIDTH-1:0] pc, branch_pc, jump_pc, mem_ea_addr;
  logic [31:0]           ir, a, b, alu_out, mdr;
  logic [31:0]           rs_data, rt_data;
  logic [5:0]            opcode, funct;
  logic [4:0]            rs, rt, rd;
  logic [31:0]           pc_ext, sign_imm, zero_imm, mem_ea, jump_full;
  logic [31:0]           rtype_result, imm_result;
  logic                  rf_we;
  logic [4:0]            rf_wa;
  logic [31:0]           rf_wd;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign sign_imm = {{16{ir[15]}}, ir[15:0]};
  assign zero_imm = {16'd0, ir[15:0]};

  assign pc_ext       = 32'(pc);
  assign mem_ea       = a + sign_imm;
  assign mem_ea_addr  = ADDR_WIDTH'(mem_ea & ~32'h3);
  assign branch_pc    = ADDR_WIDTH'(alu_out & ~32'h3);
  assign jump_full    = {pc_ext[31:28], ir[25:0], 2'b00};
  assign jump_pc      = ADDR_WIDTH'(jump_full);
  assign rtype_result = alu_compute(funct_to_alu(funct), a, b);
  assign imm_result   = (opcode == OP_ORI) ? alu_compute(ALU_OR, a, zero_imm)
                                           : alu_compute(ALU_ADD, a, sign_imm);

  // Loads write rt from the data register; ALU results go to rd for R-type
  // and rt for immediates. IR is stable through write-back.
  assign rf_we = (state == ALU_WB) || (state == MEMWB);
  assign rf_wa = ((state == MEMWB) || (opcode != OP_RTYPE)) ? rt : rd;
  assign rf_wd = (state == MEMWB) ? mdr : alu_out;

  regfile_2r1w #(.REG_COUNT(REG_COUNT)) u_regfile (
    .clk (clk),
    .reset (reset),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rs_data),
    .rd2 (rt_data),
    .we (rf_we),
    .wa (rf_wa),
    .wd (rf_wd)
  );

  // Opcode dispatch out of DECODE; anything outside the subset halts.
  always_comb begin
    decode_state = HALT;
    case (opcode)
      OP_RTYPE:      decode_state = funct_legal(funct) ? RTYPE_EX : HALT;
      OP_ADDI, OP_ORI: decode_state = IMM_EX;
      OP_LW, OP_SW:  decode_state = MEMADR;
      OP_BEQ:        decode_state = BRANCH;
      OP_J:          decode_state = JUMP;
      default:       decode_state = HALT;
    endcase
  end

  // Control FSM and datapath registers. Memory outputs are registered, so
  // every transition into an accessing state loads the request in the same
  // edge; FETCH with no request pending is only the first cycle after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ir          <= '0;
      a           <= '0;
      b           <= '0;
      alu_out     <= '0;
      mdr         <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= RESET_PC;
      mem_wdata_o <= '0;
      halt_o      <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (!mem_req_o) begin
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_addr_o <= pc;
          end else if (mem_ready_i) begin
            ir        <= mem_rdata_i;
            pc        <= pc + PC_STEP;
            mem_req_o <= 1'b0;
            state     <= DECODE;
          end
        end
        DECODE: begin
          a       <= rs_data;
          b       <= rt_data;
          alu_out <= pc_ext + {sign_imm[29:0], 2'b00};
          state   <= decode_state;
          if (decode_state == HALT) halt_o <= 1'b1;
        end
        MEMADR: begin
          alu_out    <= mem_ea;
          mem_req_o  <= 1'b1;
          mem_addr_o <= mem_ea_addr;
          if (opcode == OP_LW) begin
            mem_we_o <= 1'b0;
            state    <= MEMRD;
          end else begin
            mem_we_o    <= 1'b1;
            mem_wdata_o <= b;
            state       <= MEMWR;
          end
        end
        MEMRD: begin
          if (mem_ready_i) begin
            mdr       <= mem_rdata_i;
            mem_req_o <= 1'b0;
            state     <= MEMWB;
          end
        end
        MEMWR: begin
          if (mem_ready_i) begin
            mem_we_o   <= 1'b0;
            mem_addr_o <= pc;
            state      <= FETCH;
          end
        end
        RTYPE_EX: begin
          alu_out <= rtype_result;
          state   <= ALU_WB;
        end
        IMM_EX: begin
          alu_out <= imm_result;
          state   <= ALU_WB;
        end
        MEMWB, ALU_WB: begin
          mem_req_o  <= 1'b1;
          mem_we_o   <= 1'b0;
          mem_addr_o <= pc;
          state      <= FETCH;
        end
        BRANCH: begin
          mem_req_o <= 1'b1;
          mem_we_o  <= 1'b0;
          if (a == b) begin
            pc         <= branch_pc;
            mem_addr_o <= branch_pc;
          end else begin
            mem_addr_o <= pc;
          end
          state <= FETCH;
        end
        JUMP: begin
          pc         <= jump_pc;
          mem_req_o  <= 1'b1;
          mem_we_o   <= 1'b0;
          mem_addr_o <= jump_pc;
          state      <= FETCH;
        end
        default: begin
          mem_req_o <= 1'b0;
          mem_we_o  <= 1'b0;
          halt_o    <= 1'b1;
          state     <= HALT;
        end
      endcase
    end
  end

  // GPIO mirrors the low byte of $2, captured on the same edge that
  // writes the register so it shows the cycle after write-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_o <= '0;
    end else if (rf_we && (rf_wa == 5'd2)) begin
      gpio_o <= rf_wd[7:0];
    end
  end

  assign pc_o = pc;

endmodule

// File: tb/tb_multicycle_mips_core.sv
module tb_multicycle_mips_core;

  localparam logic [31:0] RESET_ADDR = 32'h0040_0000;
  localparam logic [31:0] ILLEGAL    = 32'hFC00_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req_o, mem_we_o, mem_ready_i, halt_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, pc_o;
  logic [7:0]  gpio_o;

  logic [31:0] imem [128];
  logic [31:0] dmem [16];
  int          fetch_cnt [128];
  int          fetch_cyc [128];
  int          wr_cnt [16];
  wr_t         wr_q [$];
  int          cycle = 0;
  int          wait_cnt = 0;
  int          data_waits = 0;
  int          errors = 0;
  int          checks = 0;

  logic [31:0] ioff;
  logic        is_imem;

  always #5 clk = ~clk;

  multicycle_mips_core #(
    .ADDR_WIDTH(32),
    .REG_COUNT(8),
    .RESET_ADDR(RESET_ADDR)
  ) dut (
    .clk (clk),
    .reset (reset),
    .mem_req_o (mem_req_o),
    .mem_we_o (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ready_i (mem_ready_i),
    .pc_o (pc_o),
    .halt_o (halt_o),
    .gpio_o (gpio_o)
  );

  // Memory model: instruction region at RESET_ADDR answers at once, the
  // data region below it waits data_waits cycles per access.
  always_comb begin
    ioff        = mem_addr_o - RESET_ADDR;
    is_imem     = (mem_addr_o >= RESET_ADDR);
    mem_rdata_i = is_imem ? imem[ioff[8:2]] : dmem[mem_addr_o[5:2]];
    mem_ready_i = mem_req_o && (is_imem || (wait_cnt >= data_waits));
  end

  always @(posedge clk) begin
    cycle    <= cycle + 1;
    wait_cnt <= (mem_req_o && !mem_ready_i) ? wait_cnt + 1 : 0;
    if (mem_req_o && mem_ready_i) begin
      if (mem_we_o) begin
        dmem[mem_addr_o[5:2]]   <= mem_wdata_o;
        wr_cnt[mem_addr_o[5:2]] <= wr_cnt[mem_addr_o[5:2]] + 1;
        wr_q.push_back('{mem_addr_o, mem_wdata_o});
      end else if (is_imem) begin
        if (fetch_cnt[ioff[8:2]] == 0) fetch_cyc[ioff[8:2]] <= cycle;
        fetch_cnt[ioff[8:2]] <= fetch_cnt[ioff[8:2]] + 1;
      end
    end
  end

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] funct);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, funct};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fetch(input int idx, input string tag);
    int n = 0;
    while (fetch_cnt[idx] == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_seen"}, 32'(fetch_cnt[idx] > 0), 32'd1);
  endtask

  task automatic wait_write(input logic [31:0] addr, input logic [31:0] data, input string tag);
    int  n = 0;
    wr_t w;
    while (wr_q.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_seen"}, 32'(wr_q.size() > 0), 32'd1);
    if (wr_q.size() > 0) begin
      w = wr_q.pop_front();
      check_output({tag, "_addr"}, w.addr, addr);
      check_output({tag, "_data"}, w.data, data);
    end
  endtask

  task automatic apply_stimulus();
    for (int i = 0; i < 128; i++) imem[i] = ILLEGAL;
    for (int i = 0; i < 16; i++) dmem[i] = '0;
    imem[0]  = enc_i(6'h08, 0, 2, 16'd5);          // addi $2,$0,5
    imem[1]  = enc_i(6'h08, 0, 3, 16'hFFFD);       // addi $3,$0,-3
    imem[2]  = enc_r(2, 3, 2, 6'h20);              // add  $2,$2,$3
    imem[3]  = enc_r(3, 2, 4, 6'h2A);              // slt  $4,$3,$2
    imem[4]  = enc_i(6'h2B, 0, 4, 16'd12);         // sw   $4,12($0)
    imem[5]  = enc_i(6'h2B, 0, 2, 16'd8);          // sw   $2,8($0)
    imem[6]  = enc_i(6'h23, 0, 5, 16'd8);          // lw   $5,8($0)
    imem[7]  = enc_i(6'h2B, 0, 5, 16'd16);         // sw   $5,16($0)
    imem[8]  = enc_i(6'h0D, 0, 6, 16'h8F0F);       // ori  $6,$0,0x8F0F
    imem[9]  = enc_i(6'h2B, 0, 6, 16'd20);         // sw   $6,20($0)
    imem[10] = enc_r(3, 2, 7, 6'h22);              // sub  $7,$3,$2
    imem[11] = enc_r(6, 7, 1, 6'h24);              // and  $1,$6,$7
    imem[12] = enc_i(6'h2B, 0, 1, 16'd24);         // sw   $1,24($0)
    imem[13] = enc_r(2, 4, 2, 6'h25);              // or   $2,$2,$4
    imem[14] = enc_i(6'h04, 0, 1, 16'd5);          // beq  $0,$1,+5 (not taken)
    imem[15] = enc_i(6'h08, 0, 6, 16'd0);          // addi $6,$0,0
    imem[16] = enc_i(6'h08, 6, 6, 16'd1);          // addi $6,$6,1
    imem[17] = enc_i(6'h04, 6, 4, 16'hFFFE);       // beq  $6,$4,-2
    imem[18] = enc_i(6'h2B, 0, 6, 16'd28);         // sw   $6,28($0)
    imem[19] = {6'h02, 26'h010_0040};              // j    0x00400100
    imem[20] = enc_i(6'h08, 0, 2, 16'h55);         // skipped
    imem[64] = enc_i(6'h08, 0, 9, 16'd7);          // addi $9,$0,7
    imem[65] = enc_r(9, 0, 2, 6'h20);              // add  $2,$9,$0
    imem[66] = enc_i(6'h2B, 0, 9, 16'd32);         // sw   $9,32($0)
    imem[67] = ILLEGAL;                            // op 0x3F
  endtask

  initial begin
    int n;
    int reqs;
    apply_stimulus();
    data_waits = 2;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_req", 32'(mem_req_o), 32'd0);
    check_output("rst_pc", pc_o, RESET_ADDR);
    check_output("rst_halt", 32'(halt_o), 32'd0);
    check_output("rst_gpio", 32'(gpio_o), 32'd0);

    reset = 1'b1;
    @(negedge clk);
    check_output("first_req", 32'(mem_req_o), 32'd1);
    check_output("first_addr", mem_addr_o, RESET_ADDR);
    check_output("first_we", 32'(mem_we_o), 32'd0);
    wait_fetch(0, "fetch0");
    check_output("pc_after_fetch", pc_o, 32'h0040_0004);

    wait_fetch(2, "fetch2");
    check_output("gpio_addi", 32'(gpio_o), 32'h05);
    wait_fetch(4, "fetch4");
    check_output("gpio_add", 32'(gpio_o), 32'h02);

    wait_write(32'd12, 32'd1, "slt_store");
    wait_write(32'd8, 32'd2, "sw_store");
    wait_write(32'd16, 32'd2, "lw_store");
    check_output("cpi_addi", 32'(fetch_cyc[1] - fetch_cyc[0]), 32'd4);
    check_output("cpi_add", 32'(fetch_cyc[3] - fetch_cyc[2]), 32'd4);
    check_output("cpi_sw_wait2", 32'(fetch_cyc[6] - fetch_cyc[5]), 32'd6);
    check_output("cpi_lw_wait2", 32'(fetch_cyc[7] - fetch_cyc[6]), 32'd7);

    wait_write(32'd20, 32'h0000_8F0F, "ori_store");
    wait_write(32'd24, 32'h0000_8F0B, "and_store");
    wait_fetch(15, "fetch15");
    check_output("gpio_or", 32'(gpio_o), 32'h03);
    check_output("cpi_beq_nt", 32'(fetch_cyc[15] - fetch_cyc[14]), 32'd3);

    wait_write(32'd28, 32'd2, "loop_store");
    check_output("loop_target_twice", 32'(fetch_cnt[16]), 32'd2);
    check_output("loop_beq_twice", 32'(fetch_cnt[17]), 32'd2);

    wait_fetch(64, "jump_target");
    check_output("pc_after_jump_fetch", pc_o, 32'h0040_0104);
    check_output("jump_skip", 32'(fetch_cnt[20]), 32'd0);
    check_output("cpi_j", 32'(fetch_cyc[64] - fetch_cyc[19]), 32'd3);
    wait_write(32'd32, 32'd0, "reg9_store");

    n = 0;
    while (!halt_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_output("halt", 32'(halt_o), 32'd1);
    check_output("gpio_reg9", 32'(gpio_o), 32'h00);
    reqs = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req_o) reqs++;
    end
    check_output("halt_no_req", 32'(reqs), 32'd0);
    check_output("addr8_writes", 32'(wr_cnt[2]), 32'd1);
    check_output("addr8_value", dmem[2], 32'd2);
    check_output("no_extra_writes", 32'(wr_q.size()), 32'd0);

    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst2_halt", 32'(halt_o), 32'd0);
    dmem[3] = 32'hDEAD_BEEF;
    wr_q.delete();
    reset = 1'b1;
    n = 0;
    while (!(mem_req_o && mem_we_o) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_output("store_pending", 32'(mem_req_o && mem_we_o), 32'd1);
    reset = 1'b0;
    #1;
    check_output("abort_req", 32'(mem_req_o), 32'd0);
    repeat (4) @(negedge clk);
    check_output("abort_mem", dmem[3], 32'hDEAD_BEEF);
    check_output("abort_no_write", 32'(wr_q.size()), 32'd0);
    check_output("abort_pc", pc_o, RESET_ADDR);
    for (int i = 0; i < 128; i++) fetch_cnt[i] = 0;
    reset = 1'b1;
    wait_fetch(0, "restart");
    check_output("restart_pc", pc_o, 32'h0040_0004);
    check_output("restart_only_first", 32'(fetch_cnt[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
